// File: rtl/conv_frame_encoder.sv
// -----------------------------------------------------------------------------
// conv_frame_encoder
//   Rate-1/2 feed-forward convolutional encoder with framing. The input bit
//   stream is cut into frames of FRAME_LEN data bits. Each frame is closed with
//   K-1 forced zero tail bits, so that the downstream Viterbi trellis ends in
//   state 0. One 2-bit symbol is emitted per encoded bit, and every output is
//   registered.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-low reset
//   enable_i   in   1   d_in is valid this cycle
//   d_in       in   1   data bit
//   ready_o    out  1   encoder accepts d_in this cycle (low during the tail)
//   valid_o    out  1   d_out carries a new symbol
//   d_out      out  2   {G0 parity, G1 parity}
//   sof_o      out  1   pulse with the first symbol of a frame
//   eof_o      out  1   pulse with the last tail symbol of a frame
//   drop_o     out  1   pulse: enable_i was high while ready_o was low
//   frame_ct_o out  16  completed frame count, wraps
// -----------------------------------------------------------------------------
module conv_frame_encoder #(
  parameter int             K         = 3,
  parameter logic [K-1:0]   G0        = 3'b111,
  parameter logic [K-1:0]   G1        = 3'b101,
  parameter int             FRAME_LEN = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        d_in,
  output logic        ready_o,
  output logic        valid_o,
  output logic [1:0]  d_out,
  output logic        sof_o,
  output logic        eof_o,
  output logic        drop_o,
  output logic [15:0] frame_ct_o
);

  localparam int BW = $clog2(FRAME_LEN + 1);
  // tail_ct counts 0..K-2. It needs at least one bit, even when K=2.
  localparam int TW = (K > 2) ? $clog2(K - 1) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_LEN);
  localparam logic [TW-1:0] LAST_TAIL = TW'(K - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_e;

  // Parity of the generator taps applied to the tap vector.
  function automatic logic gen_parity(input logic [K-1:0] v, input logic [K-1:0] g);
    return ^(v & g);
  endfunction

  state_e          state_q, state_d;
  logic [K-2:0]    sr_q, sr_d;        // sr_q[K-2] is the most recent past bit
  logic [BW-1:0]   bit_ct_q, bit_ct_d;
  logic [TW-1:0]   tail_ct_q, tail_ct_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [1:0]      dout_q, dout_d;
  logic            sof_q, sof_d;
  logic            eof_q, eof_d;
  logic            drop_q, drop_d;
  logic [15:0]     frame_ct_q, frame_ct_d;

  logic            accept_s;
  logic            emit_s;
  logic            u_s;
  logic [K-1:0]    v_s;
  logic [BW-1:0]   bit_inc_s;

  // Next-state, symbol generation and registered-output values.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_ct_d   = bit_ct_q;
    tail_ct_d  = tail_ct_q;
    dout_d     = dout_q;
    frame_ct_d = frame_ct_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;

    accept_s  = enable_i & ready_q;
    drop_d    = enable_i & ~ready_q;
    // In the tail, the input is forced to zero, whatever d_in holds.
    u_s       = (state_q == TAIL) ? 1'b0 : d_in;
    v_s       = {u_s, sr_q};
    emit_s    = accept_s | (state_q == TAIL);
    bit_inc_s = bit_ct_q + 1'b1;

    if (emit_s) begin
      valid_d = 1'b1;
      dout_d  = {gen_parity(v_s, G0), gen_parity(v_s, G1)};
      sr_d    = v_s[K-1:1];
    end else begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE, DATA: begin
        if (accept_s) begin
          sof_d    = (state_q == IDLE);
          bit_ct_d = bit_inc_s;
          if (bit_inc_s == LAST_BIT) begin
            state_d   = TAIL;
            tail_ct_d = '0;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      TAIL: begin
        tail_ct_d = tail_ct_q + 1'b1;
        if (tail_ct_q == LAST_TAIL) begin
          eof_d      = 1'b1;
          frame_ct_d = frame_ct_q + 16'd1;
          state_d    = IDLE;
          sr_d       = '0;
          bit_ct_d   = '0;
          tail_ct_d  = '0;
        end else begin
          state_d = TAIL;
        end
      end
      default: begin
        state_d   = IDLE;
        sr_d      = '0;
        bit_ct_d  = '0;
        tail_ct_d = '0;
      end
    endcase

    // The registered ready_o reflects the state being entered.
    ready_d = (state_d != TAIL);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_ct_q   <= '0;
      tail_ct_q  <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      dout_q     <= 2'b00;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      drop_q     <= 1'b0;
      frame_ct_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_ct_q   <= bit_ct_d;
      tail_ct_q  <= tail_ct_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      dout_q     <= dout_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      drop_q     <= drop_d;
      frame_ct_q <= frame_ct_d;
    end
  end

  assign ready_o    = ready_q;
  assign valid_o    = valid_q;
  assign d_out      = dout_q;
  assign sof_o      = sof_q;
  assign eof_o      = eof_q;
  assign drop_o     = drop_q;
  assign frame_ct_o = frame_ct_q;

endmodule
